// File: rtl/rr_mux_arbiter4_pkg.sv
// +----------------------------------------------------------------------+
// | rr_mux_arbiter4_pkg                                                  |
// | Shared FSM state encodings and reset pointer for the arbiter slice.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rr_mux_arbiter4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Last-owner pointer after reset; requester 0 is searched first.
  localparam logic [1:0] RST_LAST = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// +----------------------------------------------------------------------+
// | rr_pick4                                                             |
// | Combinational round-robin search over 4 requests, optional exclusion.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] w_cand;

  always_comb begin
    idx    = 2'd0;
    found  = 1'b0;
    w_cand = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_cand = start + 2'(k);
      if (!found && req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter4.sv
// +----------------------------------------------------------------------+
// | rr_mux_arbiter4                                                      |
// | Round-robin 4-way mux arbiter with bounded hold and forced rotation. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_HOLD_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [1:0]       r_last, w_last_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic             r_busy, w_busy_nxt;
  logic [1:0]       w_start, w_idx;
  logic             w_found, w_excl_en, w_load;

  // While granted, the owner is excluded so the search only sees contenders.
  assign w_start   = r_last + 2'd1;
  assign w_excl_en = (r_state == ST_GRANT);

  rr_pick4 u_pick (
    .req      (req),
    .start    (w_start),
    .excl_en  (w_excl_en),
    .excl_idx (r_last),
    .idx      (w_idx),
    .found    (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_last  <= RST_LAST;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) w_load = 1'b1;
      end
      ST_GRANT: begin
        if (!req[r_last]) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_busy_nxt  = 1'b0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold == c_HOLD_MAX) begin
          // Saturated: rotate only if someone else is waiting.
          if (w_found) w_load = 1'b1;
        end else begin
          w_hold_nxt = r_hold + c_HOLD_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_sel_nxt   = 2'b00;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
        w_last_nxt  = RST_LAST;
      end
    endcase

    if (w_load) begin
      w_state_nxt = ST_GRANT;
      w_gnt_nxt   = 4'b0001 << w_idx;
      w_sel_nxt   = w_idx;
      w_busy_nxt  = 1'b1;
      w_hold_nxt  = c_HOLD_ONE;
      w_last_nxt  = w_idx;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter4.sv
// +----------------------------------------------------------------------+
// | tb_rr_mux_arbiter4                                                   |
// | Random + directed bench for two arbiter instances (MAX_HOLD 4 and 1).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance: owner -1 means nobody holds the grant.
  int m_owner [2];
  int m_last  [2];
  int m_sel   [2];
  int m_hold  [2];
  int m_max   [2];

  always #5 clk = ~clk;

  rr_mux_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .sel(sel_a), .busy(busy_a)
  );

  rr_mux_arbiter4 #(.MAX_HOLD(1), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .sel(sel_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 3;
      m_sel[d]   = 0;
      m_hold[d]  = 0;
    end
  endtask

  task automatic model_grant(input int d, input int idx);
    m_owner[d] = idx;
    m_last[d]  = idx;
    m_sel[d]   = idx;
    m_hold[d]  = 1;
  endtask

  task automatic model_clk(input int d, input logic [3:0] r);
    int o, idx;
    o = m_owner[d];
    if (o < 0) begin
      idx = pick(r, m_last[d] + 1, -1);
      if (idx >= 0) model_grant(d, idx);
    end else if (!r[o]) begin
      idx = pick(r, o + 1, o);
      if (idx >= 0) model_grant(d, idx);
      else begin
        m_owner[d] = -1;
        m_hold[d]  = 0;
      end
    end else if (m_hold[d] >= m_max[d]) begin
      idx = pick(r, o + 1, o);
      if (idx >= 0) model_grant(d, idx);
    end else begin
      m_hold[d] = m_hold[d] + 1;
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int d);
    return (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
  endfunction

  task automatic check_all();
    check("gnt_a",  32'(gnt_a),  32'(exp_gnt(0)));
    check("sel_a",  32'(sel_a),  32'(m_sel[0]));
    check("busy_a", 32'(busy_a), 32'(m_owner[0] >= 0));
    check("gnt_b",  32'(gnt_b),  32'(exp_gnt(1)));
    check("sel_b",  32'(sel_b),  32'(m_sel[1]));
    check("busy_b", 32'(busy_b), 32'(m_owner[1] >= 0));
    check("inv_a",  32'(gnt_a),  busy_a ? 32'(4'b0001 << sel_a) : 32'd0);
    check("inv_b",  32'(gnt_b),  busy_b ? 32'(4'b0001 << sel_b) : 32'd0);
    check("oh_a",   32'($onehot0(gnt_a)), 32'd1);
    check("oh_b",   32'($onehot0(gnt_b)), 32'd1);
  endtask

  // Called just after a negative edge; returns just after the next one.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_clk(0, r);
    model_clk(1, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_gnt_a",  32'(gnt_a),  32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_sel_a",  32'(sel_a),  32'd0);
    check("rst_gnt_b",  32'(gnt_b),  32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_max[0] = 4;
    m_max[1] = 1;
    model_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Idle after reset, then a lone requester holding well past MAX_HOLD.
    steps(4'b0000, 5);
    steps(4'b0100, 10);
    steps(4'b0000, 2);

    // Full contention from reset: rotation every 4 (a) / every 1 (b) cycles.
    async_reset();
    steps(4'b1111, 20);

    // Direct handoff with no idle bubble.
    async_reset();
    steps(4'b0001, 2);
    step(4'b1010);
    steps(4'b1000, 2);
    steps(4'b0000, 1);

    // Pointer fairness after releases.
    steps(4'b0100, 2);
    steps(4'b0000, 1);
    step(4'b0101);
    steps(4'b0000, 1);
    step(4'b0101);
    steps(4'b0000, 1);

    // Reset mid-grant, then full contention restarts at requester 0.
    steps(4'b1000, 3);
    async_reset();
    steps(4'b1111, 3);

    // Randomised traffic with runs of stable requests and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      int run;
      r   = 4'($urandom_range(0, 15));
      run = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) async_reset();
      steps(r, run);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
